// File: rtl/game_tick_sequencer.sv
// Game clock for the dino player group: two-phase tick divider, IDLE/PLAYING/OVER
// sequencing, BCD score/high score and level-driven speed-up of the tick period.
module game_tick_sequencer #(
   parameter int CLK_DIV_INIT    = 8,
   parameter int CLK_DIV_MIN     = 4,
   parameter int SPEEDUP_STEP    = 2,
   parameter int TICKS_PER_LEVEL = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        game_start_pulse,
   input  logic        game_over_pulse,
   output logic [1:0]  game_tick,
   output logic        playing,
   output logic [15:0] score,
   output logic [15:0] high_score,
   output logic [3:0]  level,
   output logic        new_high
);

   localparam int CW = $clog2(CLK_DIV_INIT + 1);
   localparam int LW = $clog2(TICKS_PER_LEVEL + 1);
   localparam logic [CW-1:0] INIT_C = CW'(CLK_DIV_INIT);
   localparam logic [CW-1:0] MIN_C  = CW'(CLK_DIV_MIN);
   localparam logic [CW-1:0] STEP_C = CW'(SPEEDUP_STEP);
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [LW-1:0] TPL_M1 = LW'(TICKS_PER_LEVEL - 1);
   localparam logic [LW-1:0] LONE_C = LW'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PLAYING = 2'd1,
      S_OVER    = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] period_q, period_d;
   logic [LW-1:0] lvl_cnt_q, lvl_cnt_d;
   logic [15:0]   score_q, score_d;
   logic [15:0]   high_q, high_d;
   logic [3:0]    level_q, level_d;
   logic          tick1_q;
   logic          new_high_q, new_high_d;
   logic          tick0;
   logic [15:0]   score_inc;
   logic [4:0]    carry;

   assign tick0 = (cnt_q == '0);

   // BCD ripple increment; carry[4] set means every digit is 9 (saturated).
   assign carry[0] = 1'b1;
   for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
      logic [3:0] dig;
      assign dig = score_q[4*gi +: 4];
      assign score_inc[4*gi +: 4] = carry[gi] ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
      assign carry[gi+1] = carry[gi] & (dig == 4'd9);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = tick0 ? (period_q - ONE_C) : (cnt_q - ONE_C);
      period_d   = period_q;
      lvl_cnt_d  = lvl_cnt_q;
      level_d    = level_q;
      score_d    = score_q;
      high_d     = high_q;
      new_high_d = 1'b0;
      case (state_q)
         S_PLAYING: begin
            if (tick1_q) begin
               if (!carry[4]) begin
                  score_d = score_inc;
               end
               if (lvl_cnt_q == TPL_M1) begin
                  lvl_cnt_d = '0;
                  if (level_q != 4'd15) begin
                     level_d = level_q + 4'd1;
                  end
                  // Compare before subtracting so the period never wraps below the floor.
                  if (int'(period_q) >= CLK_DIV_MIN + SPEEDUP_STEP) begin
                     period_d = period_q - STEP_C;
                  end else begin
                     period_d = MIN_C;
                  end
               end else begin
                  lvl_cnt_d = lvl_cnt_q + LONE_C;
               end
            end
            // Game over overrides any same-cycle speed-up and ignores start.
            if (game_over_pulse) begin
               state_d  = S_OVER;
               period_d = INIT_C;
               if (score_q > high_q) begin
                  high_d     = score_q;
                  new_high_d = 1'b1;
               end
            end
         end
         default: begin
            if (game_start_pulse) begin
               state_d   = S_PLAYING;
               score_d   = '0;
               level_d   = '0;
               lvl_cnt_d = '0;
               period_d  = INIT_C;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= INIT_C - ONE_C;
         period_q   <= INIT_C;
         lvl_cnt_q  <= '0;
         score_q    <= '0;
         high_q     <= '0;
         level_q    <= '0;
         tick1_q    <= 1'b0;
         new_high_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         period_q   <= period_d;
         lvl_cnt_q  <= lvl_cnt_d;
         score_q    <= score_d;
         high_q     <= high_d;
         level_q    <= level_d;
         tick1_q    <= tick0;
         new_high_q <= new_high_d;
      end
   end

   assign game_tick  = {tick1_q, tick0};
   assign playing    = (state_q == S_PLAYING);
   assign score      = score_q;
   assign high_score = high_q;
   assign level      = level_q;
   assign new_high   = new_high_q;

endmodule
